chorus_delay_ctrl: RTL and testbench

Sequencer for the chorus effect's modulated delay line in the audio loopback path. Per accepted audio sample it writes the sample into an external single-port circular-buffer RAM, then reads back one tap at a delay modulated by a triangle LFO. It then mixes wet and dry paths in Q1.15 and emits one output sample. This replaces the register-array delay with a RAM-backed, time-multiplexed controller sitting between the codec RX and TX sample streams.

---
 rtl/chorus_delay_ctrl_pkg.sv | 34 +++
 rtl/chorus_delay_ctrl_if.sv | 24 ++
 rtl/chorus_delay_ctrl_lfo_tri.sv | 27 ++
 rtl/chorus_delay_ctrl.sv | 173 +++++++++++++++++
 tb/tb_chorus_delay_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chorus_delay_ctrl_pkg.sv
// Shared types, constants and the Q1.15 round/saturate helper for the chorus delay controller.
package chorus_pkg;

    localparam int DEPTH_LOG2 = 9;
    localparam int AW         = DEPTH_LOG2;
    localparam int DW         = 16;

    localparam logic [DW-1:0]        Q15_ONE = 16'h7FFF;
    localparam logic signed [DW-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DW-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WRITE,
        READ,
        WAIT,
        MIX
    } state_t;

    // Round a Q2.30 accumulator to nearest (half up) and clamp into a 16-bit sample.
    function automatic logic signed [DW-1:0] round_sat(input logic signed [32:0] acc);
        logic signed [32:0] shifted;
        shifted = (acc + 33'sd16384) >>> 15;
        if (shifted > 33'sd32767) begin
            return SAT_MAX;
        end else if (shifted < -33'sd32768) begin
            return SAT_MIN;
        end else begin
            return shifted[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/chorus_delay_ctrl_if.sv
// Bus to the external single-port circular-buffer RAM (read data arrives one cycle after the address).
interface chorus_delay_ctrl_if;
    import chorus_pkg::*;

    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/chorus_delay_ctrl_lfo_tri.sv
// Triangle LFO: 16-bit phase accumulator folded into a triangle and scaled to a 0..depth-1 offset.
module lfo_tri (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       step,
    input  logic [7:0] rate,
    input  logic [5:0] depth,
    output logic [5:0] off
);

    logic [15:0] acc_p;
    logic [5:0]  tri_hi;

    // Advance the phase once per accepted sample; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_p <= '0;
        end else if (step) begin
            acc_p <= acc_p + {8'd0, rate};
        end
    end

    // Only the top six triangle bits matter once the result is scaled by a 6-bit depth.
    assign tri_hi = acc_p[15] ? ~acc_p[14:9] : acc_p[14:9];
    assign off    = 6'(({6'd0, tri_hi} * {6'd0, depth}) >> 6);

endmodule

// File: rtl/chorus_delay_ctrl.sv
// RAM-backed chorus delay sequencer: clear sweep, then per sample write, modulated tap read and Q1.15 mix.
module chorus_delay_ctrl
    import chorus_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic signed [DW-1:0]  sample_in,
    input  logic [AW-1:0]         base_delay,
    input  logic [5:0]            depth,
    input  logic [7:0]            rate,
    input  logic signed [15:0]    wet_gain,
    input  logic signed [15:0]    dry_gain,
    chorus_delay_ctrl_if.master   ram,
    output logic signed [DW-1:0]  sample_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
);

    state_t state;
    state_t next_state;

    logic                 clr_run;
    logic [AW-1:0]        clr_addr;
    logic [AW-1:0]        wptr;
    logic signed [DW-1:0] sample_q;
    logic signed [DW-1:0] tap_q;

    logic                 lfo_step;
    logic [5:0]           off;
    logic [AW:0]          delay_raw;
    logic [AW-1:0]        delay_sel;
    logic [AW-1:0]        read_addr;

    logic                 ram_we_c;
    logic [AW-1:0]        ram_addr_c;
    logic [DW-1:0]        ram_wdata_c;

    logic signed [31:0]   wet_prod;
    logic signed [31:0]   dry_prod;
    logic signed [32:0]   mix_acc;

    lfo_tri u_lfo (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (lfo_step),
        .rate    (rate),
        .depth   (depth),
        .off     (off)
    );

    // Tap delay clamped to 1..511 so the tap never lands on the sample just written.
    always_comb begin
        delay_raw = {1'b0, base_delay} + {{(AW-5){1'b0}}, off};
        if (delay_raw == '0) begin
            delay_sel = AW'(1);
        end else if (delay_raw[AW]) begin
            delay_sel = '1;
        end else begin
            delay_sel = delay_raw[AW-1:0];
        end
        read_addr = wptr - delay_sel;
    end

    assign wet_prod = 32'(wet_gain) * 32'(tap_q);
    assign dry_prod = 32'(dry_gain) * 32'(sample_q);
    assign mix_acc  = 33'(wet_prod) + 33'(dry_prod);

    // State register; any reset restarts the clear sweep from address 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and RAM bus decode; clr_run holds off the first clear write until reset has been released.
    always_comb begin
        next_state  = state;
        ram_we_c    = 1'b0;
        ram_addr_c  = wptr;
        ram_wdata_c = '0;
        lfo_step    = 1'b0;
        case (state)
            CLEAR: begin
                ram_we_c   = clr_run;
                ram_addr_c = clr_addr;
                if (clr_run && (clr_addr == '1)) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (sample_valid) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                ram_we_c    = 1'b1;
                ram_wdata_c = sample_q;
                lfo_step    = 1'b1;
                next_state  = READ;
            end
            READ: begin
                ram_addr_c = read_addr;
                next_state = WAIT;
            end
            WAIT: begin
                next_state = MIX;
            end
            MIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    assign ram.we    = ram_we_c;
    assign ram.addr  = ram_addr_c;
    assign ram.wdata = ram_wdata_c;
    assign busy      = (state != IDLE);

    // Clear-sweep address counter, advancing once per zero write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_run  <= 1'b0;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_run <= 1'b1;
            if (clr_run) begin
                clr_addr <= clr_addr + AW'(1);
            end
        end
    end

    // Datapath registers: sample latch, write pointer, tap capture and the mixed output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            sample_q   <= '0;
            tap_q      <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= (state == MIX);
            if ((state == IDLE) && sample_valid) begin
                sample_q <= sample_in;
            end
            if (state == READ) begin
                wptr <= wptr + AW'(1);
            end
            if (state == WAIT) begin
                tap_q <= ram.rdata;
            end
            if (state == MIX) begin
                sample_out <= round_sat(mix_acc);
            end
        end
    end

    // Sticky flag for any sample strobe that arrives while the sequencer cannot take it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (sample_valid && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// Directed bench for chorus_delay_ctrl with a behavioural single-port RAM on the interface.
module tb_chorus_delay_ctrl;

    logic               clk;
    logic               reset_n;
    logic               sample_valid;
    logic signed [15:0] sample_in;
    logic [8:0]         base_delay;
    logic [5:0]         depth;
    logic [7:0]         rate;
    logic signed [15:0] wet_gain;
    logic signed [15:0] dry_gain;
    logic signed [15:0] sample_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    int checks;
    int failures;
    int tb_wptr;
    int write_errs;
    int lat_errs;

    logic [15:0] mem [0:511];

    chorus_delay_ctrl_if ram_bus ();

    chorus_delay_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .base_delay   (base_delay),
        .depth        (depth),
        .rate         (rate),
        .wet_gain     (wet_gain),
        .dry_gain     (dry_gain),
        .ram          (ram_bus),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous single-port RAM: write on we, registered read of the same address.
    always @(posedge clk) begin
        if (ram_bus.we) begin
            mem[ram_bus.addr] <= ram_bus.wdata;
        end
        ram_bus.rdata <= mem[ram_bus.addr];
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sends one sample from IDLE and returns its output and the tap address seen in READ.
    task automatic applyStimulus(input logic signed [15:0] s, output logic signed [15:0] y, output logic [8:0] raddr);
        int waited;
        sample_in    = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        if (ram_bus.we !== 1'b1 || ram_bus.addr !== tb_wptr[8:0] || ram_bus.wdata !== s) begin
            write_errs++;
        end
        tick();
        raddr  = ram_bus.addr;
        waited = 0;
        while (!out_valid && waited < 10) begin
            tick();
            waited++;
        end
        if (!out_valid || (waited + 2) != 5) begin
            lat_errs++;
        end
        y = sample_out;
        tb_wptr++;
        tick();
        tick();
    endtask

    // Follows the 512-cycle zero sweep that starts one edge after reset release.
    task automatic runClear(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            if (ram_bus.we !== 1'b1 || ram_bus.addr !== i[8:0] || ram_bus.wdata !== 16'd0 ||
                busy !== 1'b1 || out_valid !== 1'b0) begin
                errs++;
            end
        end
        checkOutput({tag, "_sweep"}, errs, 0);
        tick();
        checkOutput({tag, "_busy_low"}, busy, 0);
        checkOutput({tag, "_we_low"}, ram_bus.we, 0);
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            if (mem[i] !== 16'd0) begin
                errs++;
            end
        end
        checkOutput({tag, "_mem_zero"}, errs, 0);
        tb_wptr = 0;
    endtask

    initial begin
        logic signed [15:0] y;
        logic [8:0]         ra;
        int                 w;
        int                 cnt;
        int                 errs;
        int                 dmin;
        int                 dmax;
        int                 dobs;
        int                 dexp;
        int                 d128;
        logic [15:0]        ph;
        logic [5:0]         th;
        logic signed [15:0] sat_in  [4];
        int                 sat_exp [4];

        checks       = 0;
        failures     = 0;
        tb_wptr      = 0;
        write_errs   = 0;
        lat_errs     = 0;
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        base_delay   = '0;
        depth        = '0;
        rate         = '0;
        wet_gain     = '0;
        dry_gain     = '0;

        tick();
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_we", ram_bus.we, 0);
        checkOutput("rst_addr", ram_bus.addr, 0);
        checkOutput("rst_wdata", ram_bus.wdata, 0);
        checkOutput("rst_out", sample_out, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        tick();
        reset_n = 1'b1;
        runClear("clear");

        // Fixed delay of 10: only the 11th output carries the impulse.
        base_delay = 9'd10;
        depth      = 6'd0;
        wet_gain   = 16'sh7FFF;
        dry_gain   = 16'sh0000;
        for (int k = 0; k < 14; k++) begin
            w = tb_wptr;
            applyStimulus((k == 0) ? 16'sd1000 : 16'sd0, y, ra);
            checkOutput($sformatf("impulse_out%0d", k), y, (k == 10) ? 1000 : 0);
            checkOutput($sformatf("impulse_addr%0d", k), ra, (w - 10) & 511);
        end

        // Wet plus dry with delay 1; the first tap still reads a zero from the impulse run.
        base_delay = 9'd1;
        dry_gain   = 16'sh7FFF;
        sat_in[0] = 16'sd32767;  sat_exp[0] = 32766;
        sat_in[1] = 16'sd32767;  sat_exp[1] = 32767;
        sat_in[2] = -16'sd32768; sat_exp[2] = -1;
        sat_in[3] = -16'sd32768; sat_exp[3] = -32768;
        for (int k = 0; k < 4; k++) begin
            w = tb_wptr;
            applyStimulus(sat_in[k], y, ra);
            checkOutput($sformatf("sat_out%0d", k), y, sat_exp[k]);
            checkOutput($sformatf("sat_addr%0d", k), ra, (w - 1) & 511);
        end

        // Zero delay is bumped to one.
        base_delay = 9'd0;
        depth      = 6'd0;
        wet_gain   = 16'sh0000;
        dry_gain   = 16'sh0000;
        w = tb_wptr;
        applyStimulus(16'sd7, y, ra);
        checkOutput("clamp_low_addr", ra, (w - 1) & 511);

        // Maximum delay: from the fifth sample off=1 pushes the sum to 512, which must clamp to 511.
        base_delay = 9'd511;
        depth      = 6'd63;
        rate       = 8'd255;
        for (int k = 0; k < 6; k++) begin
            w = tb_wptr;
            applyStimulus(16'sd3, y, ra);
            checkOutput($sformatf("clamp_high_addr%0d", k), ra, (w - 511) & 511);
        end
        rate = 8'd0;

        // Back-to-back strobes: the second is dropped and flags overrun.
        base_delay = 9'd4;
        depth      = 6'd0;
        checkOutput("overrun_before", overrun, 0);
        sample_in    = 16'sd5;
        sample_valid = 1'b1;
        tick();
        tick();
        sample_valid = 1'b0;
        checkOutput("overrun_set", overrun, 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) begin
                cnt++;
            end
        end
        tb_wptr++;
        checkOutput("overrun_one_out", cnt, 1);
        w = tb_wptr;
        applyStimulus(16'sd9, y, ra);
        checkOutput("overrun_wptr_once", ra, (w - 4) & 511);
        checkOutput("overrun_sticky", overrun, 1);

        // Reset in the middle of READ aborts the sample and restarts the clear sweep.
        sample_in    = 16'sd11;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 1);
        checkOutput("midrst_we", ram_bus.we, 0);
        checkOutput("midrst_addr", ram_bus.addr, 0);
        checkOutput("midrst_overrun", overrun, 0);
        tick();
        tick();
        checkOutput("midrst_no_valid", out_valid, 0);
        reset_n = 1'b1;
        runClear("reclear");

        // LFO sweep from a fresh phase: delay traces 100..131 and back over 512 samples.
        base_delay = 9'd100;
        depth      = 6'd32;
        rate       = 8'd128;
        errs = 0;
        dmin = 1000;
        dmax = -1;
        d128 = -1;
        for (int n = 1; n <= 512; n++) begin
            w = tb_wptr;
            applyStimulus(16'sd0, y, ra);
            ph   = 16'((n * 128) & 16'hFFFF);
            th   = ph[15] ? ~ph[14:9] : ph[14:9];
            dexp = 100 + ((int'(th) * 32) >> 6);
            dobs = (w - int'(ra)) & 511;
            if (dobs != dexp) begin
                errs++;
            end
            if (dobs < dmin) dmin = dobs;
            if (dobs > dmax) dmax = dobs;
            if (n == 128) d128 = dobs;
        end
        checkOutput("lfo_trace", errs, 0);
        checkOutput("lfo_min", dmin, 100);
        checkOutput("lfo_max", dmax, 131);
        checkOutput("lfo_quarter", d128, 116);
        checkOutput("lfo_no_overrun", overrun, 0);

        checkOutput("write_path", write_errs, 0);
        checkOutput("latency", lat_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
